gf22_pad_pwr_sequencer: RTL and testbench

- Sequences power-up and power-down of a group of GF22 GPIO pad cells.
- Drives the shared pad_attributes bus consumed by each pad cell instance. Bit mapping: bit0 PWROK, bit1 IOPWROK, bit2 BIAS.
- Enforces BIAS → IOPWROK → PWROK ordering on power-up and the reverse on power-down, with programmable per-stage dwell times.
- Sits in the always-on domain next to the pad ring, commanded by the power manager through a level req/ack handshake.

---
 rtl/gf22_pad_pwr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_gf22_pad_pwr_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf22_pad_pwr_sequencer.sv
// Power sequencer for a GF22 GPIO pad group: BIAS -> IOPWROK -> PWROK
// order on power-up, with the reverse order on power-down.
// Ports: clk_i, rst_ni (async, active-low), pwr_req_i/pwr_ack_o (level
// req/ack), bias_dly_i/io_dly_i (stage dwell), ret_req_i (retention request),
// pad_attributes_o ({BIAS,IOPWROK,PWROK} in bits [2:0]), retc_o, busy_o.
// Optional macro GF22_PAD_SEQ_RETENTION_EN adds the RET/RET_EXIT states.
module gf22_pad_pwr_sequencer #(
  parameter int PADATTR = 16,
  parameter int DLY_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pwr_req_i,
  input  logic [DLY_W-1:0]   bias_dly_i,
  input  logic [DLY_W-1:0]   io_dly_i,
  input  logic               ret_req_i,
  output logic [PADATTR-1:0] pad_attributes_o,
  output logic               retc_o,
  output logic               pwr_ack_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_BIAS_UP  = 3'd1,
    S_IO_UP    = 3'd2,
    S_ON       = 3'd3,
    S_IO_DN    = 3'd4,
    S_BIAS_DN  = 3'd5,
    S_RET      = 3'd6,
    S_RET_EXIT = 3'd7
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [DLY_W-1:0] cnt_q;
  logic             load;
  logic [DLY_W-1:0] load_val;
  logic             expired;
  logic [2:0]       attr;

  // The stage ends on the cycle the counter holds 1 (or 0), so a
  // delay of D gives max(D,1) cycles in the stage.
  assign expired = (cnt_q <= DLY_W'(1));

`ifndef GF22_PAD_SEQ_RETENTION_EN
  logic unused_ret;
  assign unused_ret = ret_req_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= load_val;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - DLY_W'(1);
      end
    end
  end

  // Aborts are tested before expiry so a dropped request wins.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      S_OFF: begin
        if (pwr_req_i) begin
          state_d  = S_BIAS_UP;
          load     = 1'b1;
          load_val = bias_dly_i;
        end
      end
      S_BIAS_UP: begin
        if (!pwr_req_i) begin
          state_d  = S_BIAS_DN;
          load     = 1'b1;
          load_val = bias_dly_i;
        end else if (expired) begin
          state_d  = S_IO_UP;
          load     = 1'b1;
          load_val = io_dly_i;
        end
      end
      S_IO_UP: begin
        if (!pwr_req_i) begin
          state_d  = S_IO_DN;
          load     = 1'b1;
          load_val = io_dly_i;
        end else if (expired) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!pwr_req_i) begin
          state_d  = S_IO_DN;
          load     = 1'b1;
          load_val = io_dly_i;
        end
`ifdef GF22_PAD_SEQ_RETENTION_EN
        else if (ret_req_i) begin
          state_d = S_RET;
        end
`endif
      end
      S_IO_DN: begin
        if (expired) begin
          state_d  = S_BIAS_DN;
          load     = 1'b1;
          load_val = bias_dly_i;
        end
      end
      S_BIAS_DN: begin
        if (expired) begin
          state_d = S_OFF;
        end
      end
`ifdef GF22_PAD_SEQ_RETENTION_EN
      S_RET: begin
        if (!pwr_req_i) begin
          state_d  = S_IO_DN;
          load     = 1'b1;
          load_val = io_dly_i;
        end else if (!ret_req_i) begin
          state_d = S_RET_EXIT;
        end
      end
      S_RET_EXIT: begin
        state_d = S_ON;
      end
`endif
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  always_comb begin
    attr      = 3'b000;
    retc_o    = 1'b1;
    pwr_ack_o = 1'b0;
    busy_o    = 1'b1;
    unique case (state_q)
      S_OFF: begin
        busy_o = 1'b0;
      end
      S_BIAS_UP,
      S_BIAS_DN: begin
        attr = 3'b100;
      end
      S_IO_UP,
      S_IO_DN: begin
        attr = 3'b110;
      end
      S_ON: begin
        attr      = 3'b111;
        pwr_ack_o = 1'b1;
        busy_o    = 1'b0;
      end
`ifdef GF22_PAD_SEQ_RETENTION_EN
      S_RET: begin
        attr   = 3'b110;
        retc_o = 1'b0;
        busy_o = 1'b0;
      end
      S_RET_EXIT: begin
        attr = 3'b110;
      end
`endif
      default: begin
        busy_o = 1'b0;
      end
    endcase
    pad_attributes_o      = '0;
    pad_attributes_o[2:0] = attr;
  end

endmodule

// File: tb/tb_gf22_pad_pwr_sequencer.sv
// Self-checking bench for gf22_pad_pwr_sequencer: directed scenarios
// plus a randomized run against a level/direction reference model.
module tb_gf22_pad_pwr_sequencer;

  localparam int PADATTR = 16;
  localparam int DLY_W   = 8;
`ifdef GF22_PAD_SEQ_RETENTION_EN
  localparam bit RETEN = 1'b1;
`else
  localparam bit RETEN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req;
  logic               ret;
  logic [DLY_W-1:0]   bd;
  logic [DLY_W-1:0]   id;
  logic [PADATTR-1:0] attrs;
  logic               retc;
  logic               ack;
  logic               busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  gf22_pad_pwr_sequencer #(
    .PADATTR(PADATTR),
    .DLY_W  (DLY_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pwr_req_i       (req),
    .bias_dly_i      (bd),
    .io_dly_i        (id),
    .ret_req_i       (ret),
    .pad_attributes_o(attrs),
    .retc_o          (retc),
    .pwr_ack_o       (ack),
    .busy_o          (busy)
  );

  // {attrs, retc, ack, busy}
  logic [PADATTR+2:0] obs;
  assign obs = {attrs, retc, ack, busy};

  function automatic logic [PADATTR+2:0] pk(
    input logic [2:0] a, input logic r, input logic k, input logic b);
    logic [PADATTR-1:0] w;
    w = '0;
    w[2:0] = a;
    return {w, r, k, b};
  endfunction

  function automatic int mx(input logic [DLY_W-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
  endtask

  task automatic go_off;
    int n;
    req = 1'b0;
    ret = 1'b0;
    n = 0;
    while ((busy || attrs != 0) && n < 1200) begin
      tick();
      n++;
    end
    if (busy || attrs != 0) begin
      compared++;
      mismatched++;
      $display("FAIL go_off_timeout: got %h want %h", obs, pk(3'b000, 1, 0, 0));
    end
  endtask

  task automatic test_reset;
    logic [PADATTR+2:0] e;
    req = 0; ret = 0; bd = 0; id = 0;
    rst_n = 1'b0;
    #3;
    e = pk(3'b000, 1, 0, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", obs, e);
    end
    rst_n = 1'b1;
    tick();
    tick();
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL idle_off: got %h want %h", obs, e);
    end
  endtask

  task automatic test_power_up;
    logic [PADATTR+2:0] e;
    bd = 3; id = 5; req = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      e = pk((i < 3) ? 3'b100 : 3'b110, 1, 0, 1);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL power_up[%0d]: got %h want %h", i, obs, e);
      end
      tick();
    end
    e = pk(3'b111, 1, 1, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL power_up_on: got %h want %h", obs, e);
    end
  endtask

  task automatic test_power_down;
    logic [PADATTR+2:0] e;
    bd = 2; id = 4; req = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      e = pk((i < 4) ? 3'b110 : 3'b100, 1, 0, 1);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL power_down[%0d]: got %h want %h", i, obs, e);
      end
      tick();
    end
    e = pk(3'b000, 1, 0, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL power_down_off: got %h want %h", obs, e);
    end
  endtask

  task automatic test_abort;
    logic [PADATTR+2:0] e;
    logic [2:0] seq [11];
    seq = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b100,
            3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    bd = 2; id = 4; req = 1;
    repeat (4) tick();
    e = pk(3'b110, 1, 0, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL abort_io_up: got %h want %h", obs, e);
    end
    req = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      e = pk(seq[i], 1, 0, (seq[i] != 3'b000));
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL abort_seq[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 0) req = 1;
      tick();
    end
    go_off();
  endtask

  task automatic test_zero_delay;
    logic [PADATTR+2:0] e;
    logic [2:0] seq [3];
    seq = '{3'b100, 3'b110, 3'b111};
    bd = 0; id = 0; req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = pk(seq[i], 1, (i == 2), (i != 2));
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL zero_dly[%0d]: got %h want %h", i, obs, e);
      end
    end
    go_off();
    bd = 3; id = 0; req = 1;
    tick();
    bd = 9;
    for (int i = 0; i < 4; i++) begin
      e = pk((i < 3) ? 3'b100 : 3'b110, 1, 0, 1);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL dly_sample[%0d]: got %h want %h", i, obs, e);
      end
      tick();
    end
    go_off();
  endtask

  task automatic test_async_reset;
    logic [PADATTR+2:0] e;
    bd = 2; id = 5; req = 1;
    repeat (3) tick();
    e = pk(3'b110, 1, 0, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL arst_pre: got %h want %h", obs, e);
    end
    #3;
    rst_n = 1'b0;
    #1;
    e = pk(3'b000, 1, 0, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL arst_async: got %h want %h", obs, e);
    end
    req = 0;
    #2;
    rst_n = 1'b1;
    tick();
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL arst_off: got %h want %h", obs, e);
    end
    bd = 1; req = 1;
    tick();
    e = pk(3'b100, 1, 0, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL arst_restart: got %h want %h", obs, e);
    end
    go_off();
  endtask

  task automatic test_retention;
    logic [PADATTR+2:0] e;
    bd = 1; id = 1; req = 1;
    repeat (3) tick();
    ret = 1;
    tick();
    e = RETEN ? pk(3'b110, 0, 0, 0) : pk(3'b111, 1, 1, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL ret_enter: got %h want %h", obs, e);
    end
    tick();
    ret = 0;
    tick();
    e = RETEN ? pk(3'b110, 1, 0, 1) : pk(3'b111, 1, 1, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL ret_exit: got %h want %h", obs, e);
    end
    tick();
    e = pk(3'b111, 1, 1, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL ret_back_on: got %h want %h", obs, e);
    end
    ret = 1;
    tick();
    req = 0;
    tick();
    e = pk(3'b110, 1, 0, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL ret_power_down: got %h want %h", obs, e);
    end
    go_off();
  endtask

  // Model: lvl = number of attribute bits on (0..3), up = direction of
  // travel, rem = cycles left in the stage, r = 0 on / 1 ret / 2 exit.
  task automatic test_random;
    int lvl, rem, r;
    bit up;
    logic [2:0] a;
    logic [PADATTR+2:0] e;
    req = 0; ret = 0; bd = 0; id = 0;
    do_reset();
    lvl = 0; rem = 0; r = 0; up = 1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) req = ~req;
      if ($urandom_range(5) == 0) ret = ~ret;
      bd = DLY_W'($urandom_range(0, 5));
      id = DLY_W'($urandom_range(0, 5));
      if (lvl == 0) begin
        if (req) begin
          lvl = 1; up = 1; rem = mx(bd);
        end
      end else if (lvl == 3) begin
        if (r == 2) r = 0;
        else if (!req) begin
          lvl = 2; up = 0; rem = mx(id); r = 0;
        end else if (r == 1) begin
          if (!ret) r = 2;
        end else if (RETEN && ret) r = 1;
      end else if (up && !req) begin
        up = 0;
        rem = mx((lvl == 1) ? bd : id);
      end else begin
        rem--;
        if (rem == 0) begin
          if (up) begin
            lvl++;
            rem = (lvl == 2) ? mx(id) : 0;
          end else begin
            lvl--;
            rem = (lvl == 1) ? mx(bd) : 0;
          end
        end
      end
      tick();
      a = (lvl == 0) ? 3'b000 : (lvl == 1) ? 3'b100 :
          (lvl == 2 || r != 0) ? 3'b110 : 3'b111;
      e = pk(a, (r != 1), (lvl == 3 && r == 0),
             (lvl == 1 || lvl == 2 || r == 2));
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h want %h", c, obs, e);
      end
    end
    go_off();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_zero_delay();
    test_async_reset();
    test_retention();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
